vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between a pixel-fetch
// port (VGA, highest priority) and a CPU port (lower priority, one
// transaction in flight at a time).
// Optional feature macro: VRAM_ARB_BLANK_ONLY_EN -- when defined, the CPU
// may only be granted while bright=0 (blanking interval).
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bright,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DONE = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  localparam logic [7:0] STARVE_LIM_C = STARVE_LIM[7:0];
  localparam logic [7:0] WAIT_MAX_C   = 8'd255;

  state_t              state_q, state_d;
  logic                vga_valid_q, vga_valid_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                cpu_starve_q, cpu_starve_d;
  logic                gate_open;
  logic                cpu_grant;

`ifdef VRAM_ARB_BLANK_ONLY_EN
  // CPU access window: only during blanking.
  always_comb begin
    gate_open = ~bright;
  end
`else
  logic unused_bright;
  assign unused_bright = bright;

  // CPU access window: always open, bright does not affect arbitration.
  always_comb begin
    gate_open = 1'b1;
  end
`endif

  // Fixed-priority grant: VGA always wins, CPU only from IDLE.
  always_comb begin
    if ((state_q == IDLE) && cpu_req && !vga_req && gate_open) begin
      cpu_grant = 1'b1;
    end else begin
      cpu_grant = 1'b0;
    end
  end

  // RAM port mux; write enable only for a granted CPU write outside reset.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (vga_req) begin
      mem_addr = vga_addr;
      mem_we   = 1'b0;
    end else if (cpu_grant && !reset) begin
      mem_we = cpu_we;
    end else begin
      mem_we = 1'b0;
    end
  end

  // CPU transaction FSM next state and read-data capture.
  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          state_d = cpu_we ? WR_DONE : RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DONE: begin
        state_d = IDLE;
      end
      RD_WAIT: begin
        // RAM returns the CPU read data in the cycle after the grant.
        cpu_rdata_d = mem_rdata;
        state_d     = RD_DONE;
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ack and VGA valid are registered views of the next-cycle state.
  always_comb begin
    cpu_ack_d   = (state_d == WR_DONE) || (state_d == RD_DONE);
    vga_valid_d = vga_req;
  end

  // Starvation counter: counts ungranted IDLE cycles with a pending request.
  always_comb begin
    if (!cpu_req || cpu_grant) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == IDLE) begin
      if (wait_cnt_q == WAIT_MAX_C) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    // Compared on the next value so cpu_starve always tracks wait_cnt_q.
    cpu_starve_d = (wait_cnt_d >= STARVE_LIM_C);
  end

  // State register with synchronous reset; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vga_valid_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      wait_cnt_q   <= 8'd0;
      cpu_starve_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vga_valid_q  <= vga_valid_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_starve_q <= cpu_starve_d;
    end
  end

  assign vga_valid  = vga_valid_q;
  assign vga_rdata  = mem_rdata;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_starve = cpu_starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM
// and a queue scoreboard for VGA read data.
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        bright;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_valid;
  logic [15:0] vga_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_starve;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [15:0] ram [0:65535];
  logic        ram_load;
  logic [15:0] exp_written [int];
  logic [15:0] sb_q [$];
  logic        vga_pend;

`ifdef VRAM_ARB_BLANK_ONLY_EN
  localparam logic BR = 1'b0;
`else
  localparam logic BR = 1'b1;
`endif

  vram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset), .bright(bright),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_valid(vga_valid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_starve(cpu_starve),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int a);
    logic [15:0] v;
    v = 16'(a);
    return 16'hA5A5 ^ (v << 3) ^ v;
  endfunction

  function automatic logic [15:0] exp_word(input int a);
    if (exp_written.exists(a)) return exp_written[a];
    return init_word(a);
  endfunction

  // Behavioural single-port RAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the rising edge, check at the falling edge.
  task automatic cyc(input logic rs, input logic vr, input logic [15:0] va,
                     input logic cr, input logic cw, input logic [15:0] ca,
                     input logic [15:0] cd, input logic br);
    logic [15:0] e;
    @(posedge clk);
    #1;
    reset = rs; vga_req = vr; vga_addr = va; cpu_req = cr;
    cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; bright = br;
    @(negedge clk);
    if (vga_pend) begin
      chk("vga_valid", 32'(vga_valid), 32'd1);
      e = sb_q.pop_front();
      chk("vga_rdata", 32'(vga_rdata), 32'(e));
    end else begin
      chk("vga_valid_low", 32'(vga_valid), 32'd0);
    end
    if (vr) begin
      chk("vga_mem_addr", 32'(mem_addr), 32'(va));
      chk("vga_mem_we", 32'(mem_we), 32'd0);
    end
    if (rs) chk("rst_mem_we", 32'(mem_we), 32'd0);
    vga_pend = vr && !rs;
    if (vga_pend) sb_q.push_back(exp_word(int'(va)));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, BR);
  endtask

  initial begin
    reset = 1'b1; bright = 1'b0; vga_req = 1'b0; vga_addr = 16'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    vga_pend = 1'b0;
    ram_load = 1'b1;
    @(posedge clk);
    #1;
    ram_load = 1'b0;

    // Reset with a CPU write requested: no write may reach the RAM.
    cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'hFFFF, BR);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'hFFFF, BR);
    chk("rst_vga_valid", 32'(vga_valid), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_cpu_starve", 32'(cpu_starve), 32'd0);
    idle();
    chk("idle_ack", 32'(cpu_ack), 32'd0);

    // Back-to-back VGA fetches 0..7.
    for (int a = 0; a < 8; a++) begin
      cyc(1'b0, 1'b1, 16'(a), 1'b0, 1'b0, 16'h0000, 16'h0000, BR);
    end
    idle();

    // CPU write 0x1234 -> 0x0010, ack one cycle after grant.
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h1234, BR);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h0010);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_ack_grant", 32'(cpu_ack), 32'd0);
    exp_written[16'h0010] = 16'h1234;
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h1234, BR);
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    chk("wr_done_mem_we", 32'(mem_we), 32'd0);
    idle();
    chk("wr_ack_after", 32'(cpu_ack), 32'd0);

    // CPU read of 0x0010 with a VGA fetch during RD_WAIT.
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, BR);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0010);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_ack_grant", 32'(cpu_ack), 32'd0);
    cyc(1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0010, 16'h0000, BR);
    chk("rd_ack_wait", 32'(cpu_ack), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, BR);
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_data", 32'(cpu_rdata), 32'h1234);
    idle();
    chk("rd_ack_after", 32'(cpu_ack), 32'd0);
    chk("rd_data_hold", 32'(cpu_rdata), 32'h1234);

    // CPU read blocked by 10 VGA cycles; starvation flag at limit 4.
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b1, 16'(k), 1'b1, 1'b0, 16'h0020, 16'h0000, BR);
      chk("blk_wait_cnt", 32'(dut.wait_cnt_q), 32'(k - 1));
      chk("blk_starve", 32'(cpu_starve), (k - 1 >= 4) ? 32'd1 : 32'd0);
      chk("blk_ack", 32'(cpu_ack), 32'd0);
    end
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, BR);
    chk("blk_wait_cnt10", 32'(dut.wait_cnt_q), 32'd10);
    chk("blk_starve_grant", 32'(cpu_starve), 32'd1);
    chk("blk_grant_addr", 32'(mem_addr), 32'h0020);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, BR);
    chk("blk_starve_clr", 32'(cpu_starve), 32'd0);
    chk("blk_ack_wait", 32'(cpu_ack), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, BR);
    chk("blk_ack", 32'(cpu_ack), 32'd1);
    chk("blk_rdata", 32'(cpu_rdata), 32'(exp_word(32'h20)));
    idle();

    // Reset in RD_WAIT drops the read; a pending VGA fetch is suppressed.
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, BR);
    cyc(1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0030, 16'h0000, BR);
    chk("rrst_ack_wait", 32'(cpu_ack), 32'd0);
    idle();
    chk("rrst_ack", 32'(cpu_ack), 32'd0);
    chk("rrst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rrst_state", 32'(dut.state_q), 32'd0);
    idle();
    chk("rrst_ack2", 32'(cpu_ack), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, BR);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, BR);
    chk("rrst_reissue_wait", 32'(cpu_ack), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, BR);
    chk("rrst_reissue_ack", 32'(cpu_ack), 32'd1);
    chk("rrst_reissue_data", 32'(cpu_rdata), 32'(exp_word(32'h30)));
    idle();

`ifdef VRAM_ARB_BLANK_ONLY_EN
    // Blank-only: no CPU grant during visible video.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1);
      chk("blank_mem_we", 32'(mem_we), 32'd0);
      chk("blank_ack", 32'(cpu_ack), 32'd0);
      chk("blank_wait_cnt", 32'(dut.wait_cnt_q), 32'(k));
    end
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    chk("blank_grant_we", 32'(mem_we), 32'd1);
    exp_written[16'h0040] = 16'hBEEF;
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    chk("blank_ack_done", 32'(cpu_ack), 32'd1);
    idle();
`endif

    // Readback of written locations through the VGA port.
    cyc(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, BR);
    cyc(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, BR);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
